// File: rtl/gate_checker.sv
// Exhaustive two-input gate checker: walks {a,b} through 00..11 for LOOPS passes,
// compares the gate's response against a latched truth table, and reports the mismatches.
module gate_checker #(
    parameter int SETTLE_CYCLES = 2,
    parameter int LOOPS         = 1,
    parameter int ERR_W         = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [3:0]       truth_table,
    input  logic             y_in,
    output logic             a_out,
    output logic             b_out,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic [1:0]       first_fail_vec,
    output logic             first_fail_valid
);

    typedef enum logic [2:0] {IDLE, APPLY, SETTLE, SAMPLE, DONE} state_t;

    localparam logic [7:0]       SETTLE_INIT = 8'(SETTLE_CYCLES);
    localparam logic [7:0]       LAST_LOOP   = 8'(LOOPS - 1);
    localparam logic [ERR_W-1:0] ERR_MAX     = '1;

    state_t           state_q;
    logic [1:0]       vec_q;
    logic [7:0]       loop_q;
    logic [7:0]       settle_q;
    logic [3:0]       tt_q;
    logic [ERR_W-1:0] err_q;
    logic             pass_q;
    logic [1:0]       ff_vec_q;
    logic             ff_valid_q;
    logic             mismatch;

    assign mismatch = (y_in != tt_q[vec_q]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            vec_q      <= 2'd0;
            loop_q     <= 8'd0;
            settle_q   <= 8'd0;
            tt_q       <= 4'd0;
            err_q      <= '0;
            pass_q     <= 1'b0;
            ff_vec_q   <= 2'd0;
            ff_valid_q <= 1'b0;
        end else if (state_q == IDLE) begin
            // abort takes priority over start even while idle
            if (start && !abort) begin
                tt_q       <= truth_table;
                vec_q      <= 2'd0;
                loop_q     <= 8'd0;
                err_q      <= '0;
                ff_valid_q <= 1'b0;
                pass_q     <= 1'b0;
                state_q    <= APPLY;
            end
        end else if (abort) begin
            state_q <= IDLE;
            pass_q  <= 1'b0;
            vec_q   <= 2'd0;
            loop_q  <= 8'd0;
        end else begin
            case (state_q)
                APPLY: begin
                    settle_q <= SETTLE_INIT;
                    state_q  <= (SETTLE_CYCLES == 0) ? SAMPLE : SETTLE;
                end
                SETTLE: begin
                    settle_q <= settle_q - 8'd1;
                    if (settle_q <= 8'd1) state_q <= SAMPLE;
                end
                SAMPLE: begin
                    if (mismatch) begin
                        if (err_q != ERR_MAX) err_q <= err_q + 1'b1;
                        if (!ff_valid_q) begin
                            ff_vec_q   <= vec_q;
                            ff_valid_q <= 1'b1;
                        end
                    end
                    if (vec_q == 2'd3 && loop_q == LAST_LOOP) begin
                        state_q <= DONE;
                    end else begin
                        vec_q   <= vec_q + 2'd1;
                        if (vec_q == 2'd3) loop_q <= loop_q + 8'd1;
                        state_q <= APPLY;
                    end
                end
                DONE: begin
                    pass_q  <= (err_q == '0);
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Stimulus decodes straight from vec_q so it stays put from APPLY through SAMPLE
    assign a_out            = vec_q[1];
    assign b_out            = vec_q[0];
    assign busy             = (state_q != IDLE);
    assign done             = (state_q == DONE);
    assign pass             = pass_q;
    assign err_count        = err_q;
    assign first_fail_vec   = ff_vec_q;
    assign first_fail_valid = ff_valid_q;

endmodule

// File: tb/tb_gate_checker.sv
// Directed bench for gate_checker: a default instance (2 settle cycles, 1 loop, 8-bit count)
// and a 2-bit-counter, 2-loop instance for saturation; cycle 1 is the period after the start edge.
module tb_gate_checker;

    logic       clk;
    logic       rst_n;
    logic       start, abort;
    logic [3:0] truth_table;
    logic       y_in;
    logic       a_out, b_out, busy, done, pass;
    logic [7:0] err_count;
    logic [1:0] first_fail_vec;
    logic       first_fail_valid;
    logic [1:0] gate_mode;

    logic       start2, abort2;
    logic [3:0] tt2;
    logic       y2, a2, b2, busy2, done2, pass2;
    logic [1:0] err2;
    logic [1:0] ffv2;
    logic       ffvalid2;

    int checks = 0;
    int errors = 0;
    int cyc;
    int done_seen;

    gate_checker #(.SETTLE_CYCLES(2), .LOOPS(1), .ERR_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .truth_table(truth_table), .y_in(y_in), .a_out(a_out), .b_out(b_out),
        .busy(busy), .done(done), .pass(pass), .err_count(err_count),
        .first_fail_vec(first_fail_vec), .first_fail_valid(first_fail_valid)
    );

    gate_checker #(.SETTLE_CYCLES(2), .LOOPS(2), .ERR_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .abort(abort2),
        .truth_table(tt2), .y_in(y2), .a_out(a2), .b_out(b2),
        .busy(busy2), .done(done2), .pass(pass2), .err_count(err2),
        .first_fail_vec(ffv2), .first_fail_valid(ffvalid2)
    );

    // Gate under test: 0 = XOR, 1 = AND, otherwise stuck at 1
    assign y_in = (gate_mode == 2'd0) ? (a_out ^ b_out) :
                  (gate_mode == 2'd1) ? (a_out & b_out) : 1'b1;
    assign y2   = ~(a2 ^ b2);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Runs one check on the default instance; returns the cycle in which done was seen.
    task automatic run(input logic [1:0] mode, input logic [3:0] tt,
                       input int tt_flip_at, input int restart_at, output int done_cyc);
        gate_mode   = mode;
        truth_table = tt;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        done_cyc = 1;
        while (!done && done_cyc < 200) begin
            if (done_cyc == tt_flip_at) truth_table = 4'hF;
            start = (done_cyc == restart_at);
            @(posedge clk); #1;
            done_cyc++;
        end
        start = 1'b0;
        @(posedge clk); #1;
        chk("done_one_cycle", {31'd0, done}, 32'd0);
        chk("busy_after_run", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; truth_table = 4'd0; gate_mode = 2'd0;
        start2 = 1'b0; abort2 = 1'b0; tt2 = 4'b0110;
        #1;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_outputs", {22'd0, a_out, b_out, done, pass, err_count}, 32'd0);
        chk("rst_first_fail", {29'd0, first_fail_vec, first_fail_valid}, 32'd0);
        #12 rst_n = 1'b1;

        // Good XOR gate, with an ignored start mid-run
        run(2'd0, 4'b0110, -1, 3, cyc);
        chk("xor_done_cycle", cyc, 17);
        chk("xor_pass", {31'd0, pass}, 32'd1);
        chk("xor_err", {24'd0, err_count}, 32'd0);
        chk("xor_ffvalid", {31'd0, first_fail_valid}, 32'd0);
        $display("run xor: done cycle %0d pass %0d err %0d", cyc, pass, err_count);

        // AND gate against an XOR table
        run(2'd1, 4'b0110, -1, -1, cyc);
        chk("and_done_cycle", cyc, 17);
        chk("and_err", {24'd0, err_count}, 32'd3);
        chk("and_ffvec", {30'd0, first_fail_vec}, 32'd1);
        chk("and_ffvalid", {31'd0, first_fail_valid}, 32'd1);
        chk("and_pass", {31'd0, pass}, 32'd0);
        $display("run and: done cycle %0d pass %0d err %0d ffvec %0d", cyc, pass, err_count, first_fail_vec);

        // Stuck-at-1, table changed to 1111 after latch
        run(2'd2, 4'b0110, 6, -1, cyc);
        chk("stuck_err", {24'd0, err_count}, 32'd2);
        chk("stuck_ffvec", {30'd0, first_fail_vec}, 32'd0);
        chk("stuck_pass", {31'd0, pass}, 32'd0);
        repeat (3) @(posedge clk);
        #1 chk("idle_hold_err", {24'd0, err_count}, 32'd2);
        $display("run stuck1: done cycle %0d pass %0d err %0d", cyc, pass, err_count);

        // start and abort together in IDLE
        start = 1'b1; abort = 1'b1;
        @(posedge clk); #1 start = 1'b0; abort = 1'b0;
        chk("start_abort_idle", {31'd0, busy}, 32'd0);
        $display("start+abort in idle: busy %0d", busy);

        // Abort five cycles after start, stuck-at-1 gate so one error is recorded first
        gate_mode = 2'd2; truth_table = 4'b0110;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (4) @(posedge clk);
        #1 abort = 1'b1;
        chk("pre_abort_busy", {31'd0, busy}, 32'd1);
        chk("pre_abort_b", {31'd0, b_out}, 32'd1);
        @(posedge clk); #1 abort = 1'b0;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_ab", {30'd0, a_out, b_out}, 32'd0);
        chk("abort_keep_err", {24'd0, err_count}, 32'd1);
        chk("abort_keep_ff", {30'd0, first_fail_valid, first_fail_vec[0]}, 32'd2);
        done_seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (done) done_seen = 1;
        end
        chk("abort_no_done", done_seen, 0);
        chk("abort_pass", {31'd0, pass}, 32'd0);
        $display("abort: busy %0d err %0d done_seen %0d", busy, err_count, done_seen);

        run(2'd0, 4'b0110, -1, -1, cyc);
        chk("post_abort_cycle", cyc, 17);
        chk("post_abort_pass", {31'd0, pass}, 32'd1);
        $display("run after abort: done cycle %0d pass %0d", cyc, pass);

        // Second instance: every vector mismatches, counter saturates
        @(posedge clk); #1 start2 = 1'b1;
        @(posedge clk); #1 start2 = 1'b0;
        cyc = 1;
        while (!done2 && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("sat_done_cycle", cyc, 33);
        @(posedge clk); #1;
        chk("sat_err", {30'd0, err2}, 32'd3);
        chk("sat_pass", {31'd0, pass2}, 32'd0);
        chk("sat_ffvec", {29'd0, ffvalid2, ffv2}, 32'd4);
        $display("run saturate: done cycle %0d pass %0d err %0d", cyc, pass2, err2);

        // Asynchronous reset in the SETTLE of vector 1, after one error is recorded
        gate_mode = 2'd2; truth_table = 4'b0110;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        chk("pre_rst_state", {22'd0, busy, b_out, err_count}, 32'h301);
        rst_n = 1'b0;
        #1;
        chk("async_rst_busy", {31'd0, busy}, 32'd0);
        chk("async_rst_outs", {22'd0, a_out, b_out, done, pass, err_count}, 32'd0);
        chk("async_rst_ff", {29'd0, first_fail_vec, first_fail_valid}, 32'd0);
        $display("async reset: busy %0d b %0d err %0d", busy, b_out, err_count);
        #10 rst_n = 1'b1;

        run(2'd0, 4'b0110, -1, -1, cyc);
        chk("post_rst_cycle", cyc, 17);
        chk("post_rst_pass", {31'd0, pass}, 32'd1);
        $display("run after reset: done cycle %0d pass %0d", cyc, pass);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
